// File: rtl/median_pkg.sv
// Shared types for the streaming median filter frame controller.
package median_pkg;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } ctrl_state_t;

  function automatic int pad_of(input int window_size);
    return window_size / 2;
  endfunction

endpackage

// File: rtl/median_raster_cnt.sv
// Raster scan counter over the zero-padded grid, with interior / window-valid /
// last-position flags.
module median_raster_cnt #(
  parameter int CNT_W = 12,
  parameter int PAD   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] height,
  output logic             interior,
  output logic             win_valid,
  output logic             in_last,
  output logic             grid_last
);

  localparam int XW = CNT_W + 1;

  logic [XW-1:0] ex, ey;
  logic [XW-1:0] x_hi, y_hi, ex_max, ey_max;

  // x_hi / y_hi are the first right / bottom padding coordinates
  assign x_hi   = XW'(width) + XW'(PAD);
  assign y_hi   = XW'(height) + XW'(PAD);
  assign ex_max = x_hi + XW'(PAD) - XW'(1);
  assign ey_max = y_hi + XW'(PAD) - XW'(1);

  assign interior  = (ex >= XW'(PAD)) && (ex < x_hi) && (ey >= XW'(PAD)) && (ey < y_hi);
  assign win_valid = (ex >= XW'(2 * PAD)) && (ey >= XW'(2 * PAD));
  assign in_last   = (ex == x_hi - XW'(1)) && (ey == y_hi - XW'(1));
  assign grid_last = (ex == ex_max) && (ey == ey_max);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ex <= '0;
      ey <= '0;
    end else if (en) begin
      if (ex == ex_max) begin
        ex <= '0;
        ey <= (ey == ey_max) ? '0 : ey + XW'(1);
      end else begin
        ex <= ex + XW'(1);
      end
    end
  end

endmodule

// File: rtl/median_frame_ctrl.sv
// Frame sequencer for the median filter datapath: padding insertion, latency
// tracking, output backpressure and frame error reporting.
module median_frame_ctrl
  import median_pkg::*;
#(
  parameter int WINDOW_SIZE = 3,
  parameter int CNT_W       = 12,
  parameter int MAX_DIM     = 4095,
  parameter int DP_LAT      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_height,
  output logic             busy,
  output logic             done,
  output logic             err_cfg,
  output logic             err_frame,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [23:0]      s_pixel,
  input  logic             s_last,
  output logic             dp_en,
  output logic [23:0]      dp_pixel,
  input  logic [23:0]      dp_median,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [23:0]      m_pixel
);

  localparam int PAD = pad_of(WINDOW_SIZE);
  localparam int OW  = 2 * CNT_W;

  ctrl_state_t      state;
  logic [CNT_W-1:0] w_q, h_q;
  logic [OW-1:0]    out_cnt, total;
  logic [DP_LAT-1:0] vld_pipe;
  logic             interior, win_valid, in_last, grid_last;
  logic             run, drain, stall, adv, fire, out_last, accept_start;
  pixel_t           pix_in;

  function automatic logic dim_ok(input logic [CNT_W-1:0] d);
    return (d >= CNT_W'(WINDOW_SIZE)) && (d <= CNT_W'(MAX_DIM));
  endfunction

  assign run          = (state == ST_RUN);
  assign drain        = (state == ST_DRAIN);
  assign accept_start = start && (state == ST_IDLE) && dim_ok(cfg_width) && dim_ok(cfg_height);

  assign m_valid = vld_pipe[DP_LAT-1];
  assign m_pixel = dp_median;
  assign stall   = m_valid & ~m_ready;
  assign fire    = m_valid & m_ready;

  // Border positions advance on their own; interior ones wait for input data
  assign adv      = run & (~interior | s_valid) & ~stall;
  assign s_ready  = adv & interior;
  assign dp_en    = adv | (drain & ~stall);
  assign pix_in   = s_pixel;
  assign dp_pixel = (run && interior) ? pix_in : '0;

  assign total    = OW'(w_q) * OW'(h_q);
  assign out_last = (out_cnt == total - OW'(1));

  median_raster_cnt #(
    .CNT_W (CNT_W),
    .PAD   (PAD)
  ) u_raster (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept_start),
    .en        (adv),
    .width     (w_q),
    .height    (h_q),
    .interior  (interior),
    .win_valid (win_valid),
    .in_last   (in_last),
    .grid_last (grid_last)
  );

  always_ff @(posedge clk) begin
    if (accept_start) begin
      w_q <= cfg_width;
      h_q <= cfg_height;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_cfg   <= 1'b0;
      err_frame <= 1'b0;
      vld_pipe  <= '0;
      out_cnt   <= '0;
    end else begin
      done    <= 1'b0;
      err_cfg <= 1'b0;
      // Window-valid bits track the datapath, so they advance only with dp_en
      if (dp_en) vld_pipe <= {vld_pipe[DP_LAT-2:0], run & win_valid};
      if (fire) out_cnt <= out_cnt + OW'(1);
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (accept_start) begin
              state     <= ST_RUN;
              busy      <= 1'b1;
              err_frame <= 1'b0;
              out_cnt   <= '0;
            end else begin
              err_cfg <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (s_ready && (s_last != in_last)) err_frame <= 1'b1;
          if (adv && grid_last) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fire && out_last) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_median_frame_ctrl.sv
// Directed bench for median_frame_ctrl with a behavioural 3x3 median datapath model.
module tb_median_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [11:0] cfg_width, cfg_height;
  logic        busy, done, err_cfg, err_frame;
  logic        s_valid, s_ready, s_last;
  logic [23:0] s_pixel, dp_pixel, dp_median, m_pixel;
  logic        dp_en, m_valid, m_ready;

  int checks   = 0;
  int failures = 0;

  logic [7:0] img  [0:15];
  logic [7:0] expv [0:15];
  logic [7:0] ramp_exp [0:11] = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd5, 8'd6, 8'd3,
                                  8'd0, 8'd5, 8'd6, 8'd0};

  always #5 clk = ~clk;

  median_frame_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .busy       (busy),
    .done       (done),
    .err_cfg    (err_cfg),
    .err_frame  (err_frame),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_pixel    (s_pixel),
    .s_last     (s_last),
    .dp_en      (dp_en),
    .dp_pixel   (dp_pixel),
    .dp_median  (dp_median),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_pixel    (m_pixel)
  );

  // Datapath model: full-history window over the padded grid, 4-deep result pipe on dp_en
  logic [23:0] hist [0:255];
  logic [23:0] pipe [0:3];
  int hcnt = 0;
  int ew_m = 5;

  function automatic logic [23:0] win_median(input int k, input logic [23:0] cur);
    int gx, gy, idx;
    logic [7:0] v [0:8];
    logic [7:0] t;
    logic [23:0] px, r;
    gx = k % ew_m;
    gy = k / ew_m;
    r  = '0;
    if (gx >= 2 && gy >= 2) begin
      for (int c = 0; c < 3; c++) begin
        for (int dy = 0; dy < 3; dy++)
          for (int dx = 0; dx < 3; dx++) begin
            idx = k - dy * ew_m - dx;
            px  = (idx == k) ? cur : hist[idx % 256];
            v[dy * 3 + dx] = px[8 * c +: 8];
          end
        for (int i = 0; i < 9; i++)
          for (int j = 0; j < 8 - i; j++)
            if (v[j] > v[j + 1]) begin
              t = v[j]; v[j] = v[j + 1]; v[j + 1] = t;
            end
        r[8 * c +: 8] = v[4];
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst || (start && !busy)) begin
      hcnt <= 0;
      ew_m <= int'(cfg_width) + 2;
    end else if (dp_en) begin
      hist[hcnt % 256] <= dp_pixel;
      hcnt    <= hcnt + 1;
      pipe[0] <= win_median(hcnt, dp_pixel);
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i - 1];
    end
  end

  assign dp_median = pipe[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_spot;
    for (int i = 0; i < 9; i++) begin
      img[i]  = (i == 4) ? 8'd200 : 8'd10;
      expv[i] = (i == 0 || i == 2 || i == 6 || i == 8) ? 8'd0 : 8'd10;
    end
  endtask

  task automatic load_ramp;
    for (int i = 0; i < 12; i++) begin
      img[i]  = 8'(i);
      expv[i] = ramp_exp[i];
    end
  endtask

  task automatic run_frame(input int w, input int h, input bit rand_rdy,
                           input int slast_idx, input int gap_at, input int abort_after);
    int in_idx, n_out, n_done, cycles, post, gap_left, npix, last_idx;
    bit prev_stall, mv, sr, de, dn, gap_used;
    logic [23:0] prev_mp, mp;
    npix     = w * h;
    last_idx = (slast_idx >= 0) ? slast_idx : npix - 1;
    @(negedge clk);
    cfg_width = 12'(w); cfg_height = 12'(h); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("err_frame_clear_on_start", err_frame, 0);
    in_idx = 0; n_out = 0; n_done = 0; cycles = 0; post = 0;
    gap_left = 0; gap_used = 0; prev_stall = 0; prev_mp = '0;
    while (cycles < 600 && post < 6) begin
      if (abort_after >= 0 && in_idx == abort_after) begin
        s_valid = 1'b0; rst = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0; #1;
        check("abort_busy", busy, 0);
        check("abort_m_valid", m_valid, 0);
        check("abort_done", done, 0);
        return;
      end
      if (gap_at >= 0 && !gap_used && in_idx == gap_at) begin
        gap_left = 5; gap_used = 1;
      end
      s_valid = (in_idx < npix) && (gap_left == 0);
      s_pixel = (in_idx < npix) ? {3{img[in_idx]}} : 24'h0;
      s_last  = (in_idx == last_idx);
      m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      mv = m_valid; mp = m_pixel; sr = s_ready; de = dp_en; dn = done;
      if (prev_stall) begin
        check("stall_valid_hold", mv, 1);
        check("stall_pixel_hold", mp, prev_mp);
      end
      if (gap_left > 0) begin
        check("gap_dp_en", de, 0);
        gap_left--;
      end
      if (dn) begin
        n_done++;
        check("busy_low_with_done", busy, 0);
      end
      if (n_done > 0) post++;
      prev_stall = mv && !m_ready;
      prev_mp    = mp;
      @(posedge clk);
      if (s_valid && sr) in_idx++;
      if (mv && m_ready) begin
        if (n_out < npix) check($sformatf("out%0d", n_out), mp, {3{expv[n_out]}});
        n_out++;
      end
      @(negedge clk);
      cycles++;
    end
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    check("inputs_consumed", in_idx, npix);
    check("out_count", n_out, npix);
    check("done_pulses", n_done, 1);
    check("busy_idle_after_frame", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_width = '0; cfg_height = '0;
    s_valid = 1'b0; s_pixel = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err_cfg", err_cfg, 0);
    check("rst_err_frame", err_frame, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_dp_en", dp_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_dp_pixel", dp_pixel, 0);
    @(negedge clk);
    rst = 1'b0;

    // 3x3 spot image, free-running output
    load_spot();
    run_frame(3, 3, 0, -1, -1, -1);
    check("t1_err_frame", err_frame, 0);

    // 4x3 ramp with random backpressure
    load_ramp();
    run_frame(4, 3, 1, -1, -1, -1);
    check("t2_err_frame", err_frame, 0);

    // Illegal width is refused
    @(negedge clk);
    cfg_width = 12'd2; cfg_height = 12'd3; start = 1'b1; s_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t3_err_cfg_pulse", err_cfg, 1);
    check("t3_busy", busy, 0);
    check("t3_s_ready", s_ready, 0);
    check("t3_dp_en", dp_en, 0);
    @(negedge clk);
    check("t3_err_cfg_one_cycle", err_cfg, 0);
    check("t3_busy_still_low", busy, 0);
    s_valid = 1'b0;

    // Early s_last: error sticks, frame still completes
    load_spot();
    run_frame(3, 3, 0, 4, -1, -1);
    check("t4_err_frame_set", err_frame, 1);
    repeat (3) @(negedge clk);
    check("t4_err_frame_sticky", err_frame, 1);

    // Input gap mid-row
    run_frame(3, 3, 0, -1, 4, -1);
    check("t6_err_frame", err_frame, 0);

    // Reset mid-frame, then a clean frame
    run_frame(3, 3, 0, -1, -1, 4);
    run_frame(3, 3, 0, -1, -1, -1);
    check("t5_err_frame", err_frame, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
